data_mem_arbiter: RTL



---
 rtl/data_mem_pkg.sv | 16 +
 rtl/data_mem.sv | 28 ++
 rtl/data_mem_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants and types for the data memory arbiter slice.
`timescale 1ns/1ps
package data_mem_pkg;

   localparam int MEM_SIZE_DEF   = 512;
   localparam int DATA_WIDTH_DEF = 16;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DMA  = 1'b1;

endpackage

// File: rtl/data_mem.sv
// 1R1W synchronous word memory; read address is registered on the same edge as a write.
`timescale 1ns/1ps
module data_mem
   import data_mem_pkg::*;
#(
   parameter int MEM_SIZE   = MEM_SIZE_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   localparam int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
   input  logic                  clk,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

   // Contents and output are deliberately not reset.
   always_ff @(posedge clk) begin
      if (write_enable) begin
         mem[write_addr] <= write_data;
      end
      data_out <= mem[read_addr];
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter sharing one data_mem between the core LSU (port 0) and the DMA/debug loader (port 1).
`timescale 1ns/1ps
module data_mem_arbiter
   import data_mem_pkg::*;
#(
   parameter int MEM_SIZE   = MEM_SIZE_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ARB_MODE   = 0,
   localparam int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata
);

   localparam logic FIXED_PRI = (ARB_MODE == int'(ARB_FIXED));

   logic                  last_grant;
   logic                  rsp_pending;
   logic                  rsp_owner;
   logic                  gnt0;
   logic                  gnt1;
   logic                  gnt_any;
   logic                  gnt_port;
   logic                  gnt_we;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic [DATA_WIDTH-1:0] gnt_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Port 0 wins contention under fixed priority, or in round-robin when port 1 went last.
   always_comb begin
      gnt0      = req0_valid & (~req1_valid | FIXED_PRI | (last_grant == PORT_DMA));
      gnt1      = req1_valid & ~gnt0;
      gnt_any   = gnt0 | gnt1;
      gnt_port  = gnt1 ? PORT_DMA : PORT_CORE;
      gnt_we    = gnt1 ? req1_we    : req0_we;
      gnt_addr  = gnt1 ? req1_addr  : req0_addr;
      gnt_wdata = gnt1 ? req1_wdata : req0_wdata;
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant  <= PORT_DMA;
         rsp_pending <= 1'b0;
         rsp_owner   <= PORT_CORE;
      end else begin
         if (gnt_any) begin
            last_grant <= gnt_port;
         end
         rsp_pending <= gnt_any & ~gnt_we;
         rsp_owner   <= gnt_port;
      end
   end

   data_mem #(
      .MEM_SIZE   (MEM_SIZE),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_data_mem (
      .clk          (clk),
      .write_enable (gnt_any & gnt_we),
      .write_addr   (gnt_addr),
      .write_data   (gnt_wdata),
      .read_addr    (gnt_addr),
      .data_out     (mem_rdata)
   );

   assign rsp0_valid = rsp_pending & (rsp_owner == PORT_CORE);
   assign rsp1_valid = rsp_pending & (rsp_owner == PORT_DMA);
   assign rsp0_rdata = mem_rdata;
   assign rsp1_rdata = mem_rdata;

endmodule
